// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Load/store access controller for a 64-word data memory.
// A request is accepted in IDLE. Its effective address is (base[5:0] + off) mod 64.
// A request whose base has any bit set above the word-address range goes
// straight to RESP with rsp_err set. Such a request never touches memory.
// Any other request spends exactly one cycle in ACCESS and then moves to RESP.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_base, req_off,
//   req_wdata                          request fields (captured at accept)
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata, rsp_err                 response payload
//   mem_addr, mem_read,
//   mem_wdata, mem_rdata               data-memory port (mem_rdata is combinational)
//   txn_count                          completed-response counter (wraps)
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | one-cycle memory access (write strobe or read sample)
// RESP   | response held until rsp_ready
module mem_access_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_off,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        txn_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              we_r;
  logic              base_err;
  logic [ADDR_W-1:0] eff_addr;

  assign base_err = |req_base[DATA_W-1:ADDR_W];
  // Carry out of the word-address range is dropped on purpose: addresses wrap.
  assign eff_addr = req_base[ADDR_W-1:0] + req_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = base_err ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_read is decoded from the state register rather than registered.
  // An asynchronous reset therefore drops a pending write strobe at once.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_read  = !((state == ACCESS) && we_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (base_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              // The memory port keeps its last address/data while not in ACCESS.
              we_r      <= req_we;
              mem_addr  <= eff_addr;
              mem_wdata <= req_wdata;
            end
          end
        end
        ACCESS: begin
          rsp_rdata <= we_r ? '0 : mem_rdata;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            txn_count <= txn_count + 8'd1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  typedef struct {
    logic [15:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_base = '0;
  logic [5:0]  req_off = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  mem_addr;
  logic        mem_read;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  txn_count;

  logic [15:0] mem     [64];
  logic [15:0] ref_mem [64];
  logic        preload = 1'b1;
  int          wr_cycles = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_txn = 8'd0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_base(req_base), .req_off(req_off), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .txn_count(txn_count)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 5) ? 16'd5 : 16'(i * 257);
  endfunction

  // Data memory: combinational read, write on a clock edge while mem_read is low.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (!mem_read) begin
      mem[mem_addr] <= mem_wdata;
      wr_cycles     <= wr_cycles + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [15:0] base, input logic [5:0] off,
                         input logic [15:0] wdata, input int stall);
    logic        err;
    logic [5:0]  ea;
    logic [15:0] erd;
    int          w0;
    exp_t        e;
    err = |base[15:6];
    ea  = base[5:0] + off;
    erd = (err || we) ? 16'd0 : ref_mem[ea];
    if (!err && we) ref_mem[ea] = wdata;
    e.rd = erd;
    e.err = err;
    exp_q.push_back(e);

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_base = base; req_off = off; req_wdata = wdata;
    rsp_ready = (stall == 0);
    w0 = wr_cycles;
    @(negedge clk);
    // Request inputs now change; the controller is busy, so they must be ignored.
    req_valid = 1'b1; req_we = ~we; req_base = 16'($urandom); req_off = 6'($urandom);
    req_wdata = 16'($urandom);
    if (!err) begin
      chk("access_no_rsp", rsp_valid, 0);
      chk("access_addr", mem_addr, ea);
      chk("access_read", mem_read, !we);
      chk("access_ready", req_ready, 0);
      @(negedge clk);
    end
    chk("rsp_valid_latency", rsp_valid, 1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_ready", req_ready, 0);
      chk("stall_rdata", rsp_rdata, e.rd);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    e = exp_q.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rd);
    chk("rsp_err", rsp_err, e.err);
    exp_txn = exp_txn + 8'd1;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
    chk("post_ready", req_ready, 1);
    chk("txn_count", txn_count, exp_txn);
    chk("write_cycles", wr_cycles - w0, (!err && we) ? 1 : 0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_txn", txn_count, 0);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;

    run_req(1'b0, 16'd3, 6'd2, 16'h0000, 0);          // load word 5
    run_req(1'b1, 16'd10, 6'd0, 16'hBEEF, 0);         // store
    run_req(1'b0, 16'd10, 6'd0, 16'h0000, 0);         // read it back
    run_req(1'b0, 16'd60, 6'd6, 16'h0000, 0);         // wraps to word 2
    run_req(1'b0, 16'h0040, 6'd0, 16'h0000, 0);       // out of range
    run_req(1'b0, 16'd10, 6'd0, 16'h0000, 4);         // backpressure
    run_req(1'b1, 16'h8001, 6'd3, 16'h1111, 2);       // rejected store, stalled

    // Reset while a store to word 7 is in ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_base = 16'd7; req_off = 6'd0; req_wdata = 16'hDEAD;
    rsp_ready = 1'b1;
    w0 = wr_cycles;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_access_write", mem_read, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_read", mem_read, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_txn = 8'd0;
    chk("mid_rst_no_write", wr_cycles - w0, 0);
    chk("mid_rst_word7", mem[7], ref_mem[7]);
    chk("mid_rst_txn", txn_count, 0);
    chk("mid_rst_rsp_valid2", rsp_valid, 0);

    // Enough mixed traffic to wrap the 8-bit counter.
    for (int n = 0; n < 260; n++) begin
      logic [15:0] b;
      b = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) b = b | 16'($urandom_range(1, 1023) << 6);
      run_req(1'($urandom_range(0, 1)), b, 6'($urandom), 16'($urandom),
              ($urandom_range(0, 5) == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, 6, data-memory word-address width (64 words).
REQ-002 Parameter: DATA_W, 16, data word width.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  in  1  load/store request present.
REQ-006 Port: req_ready  out  1  block can accept a request this cycle.
REQ-007 Port: req_we  in  1  1 = store, 0 = load.
REQ-008 Port: req_base  in  DATA_W  base address (register value).
REQ-009 Port: req_off  in  ADDR_W  unsigned offset.
REQ-010 Port: req_wdata  in  DATA_W  store data.
REQ-011 Port: rsp_valid  out  1  response available.
REQ-012 Port: rsp_ready  in  1  consumer accepts response.
REQ-013 Port: rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
REQ-014 Port: rsp_err  out  1  request rejected as out of range.
REQ-015 Port: mem_addr  out  ADDR_W  data-memory word address.
REQ-016 Port: mem_read  out  1  data-memory read select (1 = read, 0 = write).
REQ-017 Port: mem_wdata  out  DATA_W  data-memory write data.
REQ-018 Port: mem_rdata  in  DATA_W  data-memory read data (combinational).
REQ-019 Port: txn_count  out  8  completed-response counter.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Handshake: request accepted on a rising edge with req_valid=1 and req_ready=1; req_we, address and req_wdata are registered at acceptance.
REQ-022 Effective address = (req_base[5:0] + req_off) mod 64; carry out of bit 5 is discarded (wrap-around, no error).
REQ-023 Error: req_base[15:6] != 0 at acceptance -> IDLE to RESP directly, rsp_err=1, rsp_rdata=0, no memory access.
REQ-024 Valid request: IDLE to ACCESS; ACCESS lasts exactly one cycle, then RESP.
REQ-025 ACCESS: mem_addr = effective address; mem_read = ~req_we (registered); mem_wdata = registered store data.
REQ-026 Outside ACCESS: mem_read SHALL be 1, mem_addr held at last value, mem_wdata held; no write ever occurs outside ACCESS.
REQ-027 Load: mem_rdata sampled on the edge leaving ACCESS into rsp_rdata; store: rsp_rdata=0.
REQ-028 Latency: accept at edge N -> rsp_valid=1 after edge N+2 (valid) or after edge N+1 (error).
REQ-029 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until the edge with rsp_ready=1; then go to IDLE.
REQ-030 rsp_ready while not in RESP SHALL be ignored; back-to-back requests are spaced by at least one IDLE cycle.
REQ-031 txn_count increments by 1 on every response handshake (including errors), wraps 255 -> 0.
REQ-032 Request inputs changing while not in IDLE SHALL have no effect.

Reset
REQ-033 On rst_n=0 (asynchronously): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_read=1, mem_addr=0, mem_wdata=0, txn_count=0.
REQ-034 Reset asserted during ACCESS or RESP SHALL abort the transaction: no write completed after the reset edge, no response produced, counter not incremented.
REQ-035 After rst_n deasserts, the first rising edge may accept a request.

Verification
REQ-036 Load: memory word 5 preset to 5; base=3, off=2, we=0, rsp_ready=1 -> mem_addr=5, mem_read=1 during ACCESS; rsp_rdata=5, rsp_err=0 at N+2; txn_count=1.
REQ-037 Store then load: store 16'hBEEF at base=10, off=0 -> mem_read=0 for exactly one cycle at addr 10; subsequent load of addr 10 returns 16'hBEEF.
REQ-038 Wrap: base=60, off=6 -> mem_addr=2, rsp_err=0.
REQ-039 Error: base=16'h0040, off=0 -> rsp_valid at N+1, rsp_err=1, rsp_rdata=0, mem_read stays 1 throughout.
REQ-040 Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; one cycle after rsp_ready=1 -> req_ready=1, txn_count incremented once.
REQ-041 Reset mid-op: assert rst_n=0 during ACCESS of a store to addr 7 -> mem_read=1 immediately, memory word 7 unchanged after reset, txn_count=0, rsp_valid=0.
